fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the decode/control unit.
- Owns the PC register and drives the instruction-memory request with a done handshake, so it supports both single-cycle and multicycle memory.
- Holds the IF/ID register that presents a 16-bit instruction and PC+2 to decode.
- Handles downstream stall, branch/jump redirect, and local HALT detection (opcode 5'b00000) so fetch stops after HALT.

Parameters:
- PC_W, 16, width of PC and instruction address.
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, bubble instruction (opcode 5'b00001) placed in IF/ID on flush or empty cycle.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_addr  output  PC_W  instruction-memory address; equals current PC.
- imem_rd  output  1  instruction-memory read request.
- imem_data  input  16  instruction word; valid only when imem_done=1.
- imem_done  input  1  memory response valid; tie to 1 for single-cycle memory.
- stall  input  1  decode/hazard stall; IF/ID must hold its contents.
- redirect  input  1  taken branch/jump/JR/JAL(R) from downstream.
- redirect_pc  input  PC_W  target PC for the redirect.
- instr_out  output  16  IF/ID instruction, fed to decode.
- pc2_out  output  PC_W  IF/ID PC+2, used for branch offsets and JAL link.
- valid_out  output  1  IF/ID holds a real instruction (0 = bubble).
- halted  output  1  fetch is halted after HALT was accepted.

Behaviour:
- Reset (async): pc=RESET_PC, state=FETCH, instr_out=NOP_INSTR, pc2_out=0, valid_out=0, halted=0, hold buffer=0.
- States: FETCH, WAIT, HOLD, DROP, HALTED.
- Outputs by state:
  - imem_rd=1 in FETCH, WAIT and DROP; 0 in HOLD and HALTED.
  - imem_addr=pc in every state.
  - halted=1 only in HALTED.
- Per-edge priority: rst > redirect > stall > imem_done.
- Redirect, any state:
  - pc<=redirect_pc; IF/ID<=NOP_INSTR, valid_out<=0; hold buffer discarded.
  - Next state is DROP if a request is outstanding (state WAIT, or FETCH with imem_done=0); otherwise FETCH.
  - Redirect exits HALTED, because a HALT fetched behind a taken branch is speculative.
- FETCH/WAIT, imem_done=1, stall=0 (accept):
  - IF/ID<=imem_data, pc2_out<=pc+2, valid_out<=1, pc<=pc+2.
  - PC arithmetic is modulo 2^PC_W: 16'hFFFE+2 wraps to 16'h0000.
  - If imem_data[15:11]==5'b00000 (HALT): next state HALTED and pc is not incremented. Otherwise next state FETCH.
- FETCH/WAIT, imem_done=1, stall=1:
  - Hold buffer<=imem_data (with its pc+2); pc<=pc+2 unless the word is a HALT.
  - IF/ID unchanged; next state HOLD.
- FETCH/WAIT, imem_done=0:
  - stall=0: IF/ID<=NOP_INSTR, valid_out<=0 (bubble).
  - stall=1: IF/ID unchanged.
  - Next state WAIT.
- HOLD: when stall=0, IF/ID<=buffer, valid_out<=1; next state HALTED if the buffer holds a HALT, else FETCH.
- DROP: the stale response is discarded when imem_done=1; next state FETCH. The new PC is not re-requested until FETCH.
- HALTED:
  - IF/ID holds the HALT until stall=0, then shows NOP_INSTR with valid_out=0.
  - The state is exited only by rst or redirect.
- Single-cycle memory (imem_done=1 always) gives zero-bubble, one-instruction-per-cycle fetch. Latency from PC to IF/ID is one edge.

Decomposition:
- Shared package/include: opcode constants (OP_HALT=5'b00000, OP_NOP=5'b00001), NOP_INSTR, and the state encodings.
- One natural sub-module: pc_reg, a PC_W-bit register with async reset to RESET_PC and load enable. It is reused by the PC and by the IF/ID pc2 field.

Test Plan:
- Single-cycle memory, image 16'h4000 at 0 and 16'h4100 at 2 → instr_out 16'h4000 then 16'h4100; pc2_out 2 then 4; valid_out=1 each cycle.
- imem_done low 3 cycles → imem_addr stable; valid_out=0 (bubble) for 3 cycles, then the instruction with valid_out=1 and pc advanced exactly by 2.
- stall=1 for 2 cycles while a response arrives → IF/ID unchanged; the word is buffered and appears on the first cycle stall=0; no fetch is lost or duplicated.
- redirect to 16'h0100 while in WAIT → IF/ID=16'h0800 with valid_out=0; late imem_done is dropped; next imem_addr=16'h0100.
- HALT (16'h0000) fetched at 16'h0006 → halted=1, imem_rd=0, pc stays 16'h0006; a subsequent redirect to 16'h0020 clears halted and resumes fetch.
- rst asserted mid-WAIT (async, off clock edge) → pc=0, valid_out=0, instr_out=16'h0800, state FETCH, all outputs immediately.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared opcode constants and fetch FSM state encodings.
package fetch_stage_pkg;
  localparam logic [4:0]  OP_HALT   = 5'b00000;
  localparam logic [4:0]  OP_NOP    = 5'b00001;
  localparam logic [15:0] NOP_INSTR = {OP_NOP, 11'd0};

  typedef enum logic [2:0] {
    FETCH,
    WAIT,
    HOLD,
    DROP,
    HALTED
  } fetch_state_e;

  function automatic logic is_halt(input logic [15:0] instr);
    return instr[15:11] == OP_HALT;
  endfunction
endpackage

// File: rtl/pc_reg.sv
// Load-enabled register with async reset to a configurable value.
module pc_reg #(
  parameter int          W         = 16,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= RESET_VAL;
    else if (load) q <= d;
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem request/done handshake, IF/ID register,
// stall hold buffer, redirect and HALT handling.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int               PC_W      = 16,
  parameter logic [PC_W-1:0]  RESET_PC  = '0,
  parameter logic [15:0]      NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_rd,
  input  logic [15:0]     imem_data,
  input  logic            imem_done,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [15:0]     instr_out,
  output logic [PC_W-1:0] pc2_out,
  output logic            valid_out,
  output logic            halted
);
  fetch_state_e state, state_n;

  logic [PC_W-1:0] pc, pc_inc, pc_d, pc2_d;
  logic            pc_ld, pc2_ld;
  logic            ifid_ld, valid_d;
  logic [15:0]     instr_d;
  logic            buf_ld, buf_clr;
  logic [15:0]     buf_instr;
  logic [PC_W-1:0] buf_pc2;

  assign pc_inc    = pc + PC_W'(2);
  assign imem_addr = pc;
  assign imem_rd   = (state == FETCH) || (state == WAIT) || (state == DROP);
  assign halted    = (state == HALTED);

  pc_reg #(.W(PC_W), .RESET_VAL(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .load(pc_ld), .d(pc_d), .q(pc)
  );

  pc_reg #(.W(PC_W), .RESET_VAL('0)) u_pc2 (
    .clk(clk), .rst(rst), .load(pc2_ld), .d(pc2_d), .q(pc2_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      instr_out <= NOP_INSTR;
      valid_out <= 1'b0;
      buf_instr <= '0;
      buf_pc2   <= '0;
    end else begin
      state <= state_n;
      if (ifid_ld) begin
        instr_out <= instr_d;
        valid_out <= valid_d;
      end
      if (buf_clr) begin
        buf_instr <= '0;
        buf_pc2   <= '0;
      end else if (buf_ld) begin
        buf_instr <= imem_data;
        buf_pc2   <= pc_inc;
      end
    end
  end

  always_comb begin
    state_n = state;
    pc_ld   = 1'b0;
    pc_d    = pc_inc;
    pc2_ld  = 1'b0;
    pc2_d   = pc_inc;
    ifid_ld = 1'b0;
    instr_d = NOP_INSTR;
    valid_d = 1'b0;
    buf_ld  = 1'b0;
    buf_clr = 1'b0;
    if (redirect) begin
      // A request still in flight must have its response swallowed in DROP.
      pc_ld   = 1'b1;
      pc_d    = redirect_pc;
      ifid_ld = 1'b1;
      buf_clr = 1'b1;
      state_n = (state == WAIT || (state == FETCH && !imem_done)) ? DROP : FETCH;
    end else begin
      case (state)
        FETCH, WAIT: begin
          if (imem_done) begin
            pc_ld = !is_halt(imem_data);
            if (!stall) begin
              ifid_ld = 1'b1;
              instr_d = imem_data;
              valid_d = 1'b1;
              pc2_ld  = 1'b1;
              state_n = is_halt(imem_data) ? HALTED : FETCH;
            end else begin
              buf_ld  = 1'b1;
              state_n = HOLD;
            end
          end else begin
            ifid_ld = !stall;
            state_n = WAIT;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_ld = 1'b1;
            instr_d = buf_instr;
            valid_d = 1'b1;
            pc2_ld  = 1'b1;
            pc2_d   = buf_pc2;
            state_n = is_halt(buf_instr) ? HALTED : FETCH;
          end
        end
        DROP: begin
          if (imem_done) state_n = FETCH;
        end
        HALTED: begin
          ifid_ld = !stall;
        end
        default: state_n = FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; snapshot = {instr, pc2, valid, addr, rd, halted}.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] imem_addr, imem_data, instr_out, pc2_out, redirect_pc;
  logic        imem_rd, imem_done, stall, redirect, valid_out, halted;
  logic [15:0] mem [0:255];
  logic [50:0] snap, exp_v;
  int total = 0;
  int bad   = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .imem_data(imem_data), .imem_done(imem_done), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_out(instr_out),
    .pc2_out(pc2_out), .valid_out(valid_out), .halted(halted)
  );

  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr[8:1]];
  assign snap = {instr_out, pc2_out, valid_out, imem_addr, imem_rd, halted};

  task automatic do_reset();
    rst = 1'b1; imem_done = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1; #1;
    exp_v = {16'h0800, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
    total++;
    if (snap !== exp_v) begin bad++; $display("FAIL reset got %h exp %h", snap, exp_v); end
    rst = 1'b0;
  endtask

  task automatic test_single_cycle();
    do_reset();
    step();
    exp_v = {16'h4000, 16'h0002, 1'b1, 16'h0002, 1'b1, 1'b0};
    total++;
    if (snap !== exp_v) begin bad++; $display("FAIL single0 got %h exp %h", snap, exp_v); end
    step();
    exp_v = {16'h4100, 16'h0004, 1'b1, 16'h0004, 1'b1, 1'b0};
    total++;
    if (snap !== exp_v) begin bad++; $display("FAIL single1 got %h exp %h", snap, exp_v); end
  endtask

  task automatic test_wait();
    do_reset();
    imem_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_v = {16'h0800, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
      total++;
      if (snap !== exp_v) begin bad++; $display("FAIL wait%0d got %h exp %h", i, snap, exp_v); end
    end
    imem_done = 1'b1;
    step();
    exp_v = {16'h4000, 16'h0002, 1'b1, 16'h0002, 1'b1, 1'b0};
    total++;
    if (snap !== exp_v) begin bad++; $display("FAIL wait_done got %h exp %h", snap, exp_v); end
  endtask

  task automatic test_stall();
    do_reset();
    step();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      exp_v = {16'h4000, 16'h0002, 1'b1, 16'h0004, 1'b0, 1'b0};
      total++;
      if (snap !== exp_v) begin bad++; $display("FAIL stall_hold%0d got %h exp %h", i, snap, exp_v); end
    end
    stall = 1'b0;
    step();
    exp_v = {16'h4100, 16'h0004, 1'b1, 16'h0004, 1'b1, 1'b0};
    total++;
    if (snap !== exp_v) begin bad++; $display("FAIL stall_release got %h exp %h", snap, exp_v); end
    step();
    exp_v = {16'h4200, 16'h0006, 1'b1, 16'h0006, 1'b1, 1'b0};
    total++;
    if (snap !== exp_v) begin bad++; $display("FAIL stall_next got %h exp %h", snap, exp_v); end
  endtask

  task automatic test_redirect();
    do_reset();
    imem_done = 1'b0;
    step();
    redirect = 1'b1; redirect_pc = 16'h0100;
    step();
    redirect = 1'b0;
    exp_v = {16'h0800, 16'h0000, 1'b0, 16'h0100, 1'b1, 1'b0};
    total++;
    if (snap !== exp_v) begin bad++; $display("FAIL redir got %h exp %h", snap, exp_v); end
    imem_done = 1'b1;
    step();
    total++;
    if (snap !== exp_v) begin bad++; $display("FAIL redir_drop got %h exp %h", snap, exp_v); end
    step();
    exp_v = {16'h4800, 16'h0102, 1'b1, 16'h0102, 1'b1, 1'b0};
    total++;
    if (snap !== exp_v) begin bad++; $display("FAIL redir_resume got %h exp %h", snap, exp_v); end
  endtask

  task automatic test_halt();
    do_reset();
    step(); step(); step(); step();
    exp_v = {16'h0000, 16'h0008, 1'b1, 16'h0006, 1'b0, 1'b1};
    total++;
    if (snap !== exp_v) begin bad++; $display("FAIL halt got %h exp %h", snap, exp_v); end
    step();
    exp_v = {16'h0800, 16'h0008, 1'b0, 16'h0006, 1'b0, 1'b1};
    total++;
    if (snap !== exp_v) begin bad++; $display("FAIL halt_idle got %h exp %h", snap, exp_v); end
    redirect = 1'b1; redirect_pc = 16'h0020;
    step();
    redirect = 1'b0;
    exp_v = {16'h0800, 16'h0008, 1'b0, 16'h0020, 1'b1, 1'b0};
    total++;
    if (snap !== exp_v) begin bad++; $display("FAIL halt_exit got %h exp %h", snap, exp_v); end
    step();
    exp_v = {16'h4500, 16'h0022, 1'b1, 16'h0022, 1'b1, 1'b0};
    total++;
    if (snap !== exp_v) begin bad++; $display("FAIL halt_resume got %h exp %h", snap, exp_v); end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0;
    step();
    exp_v = {16'h4300, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    total++;
    if (snap !== exp_v) begin bad++; $display("FAIL wrap got %h exp %h", snap, exp_v); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step();
    imem_done = 1'b0;
    step();
    #3 rst = 1'b1;
    #1;
    exp_v = {16'h0800, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
    total++;
    if (snap !== exp_v) begin bad++; $display("FAIL async_rst got %h exp %h", snap, exp_v); end
    #1 rst = 1'b0;
    imem_done = 1'b1;
    step();
    exp_v = {16'h4000, 16'h0002, 1'b1, 16'h0002, 1'b1, 1'b0};
    total++;
    if (snap !== exp_v) begin bad++; $display("FAIL async_rst_resume got %h exp %h", snap, exp_v); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0800;
    mem[0]   = 16'h4000;
    mem[1]   = 16'h4100;
    mem[2]   = 16'h4200;
    mem[3]   = 16'h0000;
    mem[16]  = 16'h4500;
    mem[128] = 16'h4800;
    mem[255] = 16'h4300;
    imem_done = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    test_reset();
    test_single_cycle();
    test_wait();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
